// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI register block APB requester: register map,
// requester FSM states and the layout of a queued command word.
package spi_apb_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_CR1   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CR2   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_BR    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_DR_RD = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SR    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DR_WR = 3'd5;

    // Command word: {write, addr[2:0], wdata[7:0]}
    localparam int unsigned CMD_W         = 1 + ADDR_W + DATA_W;
    localparam int unsigned CMD_WDATA_LSB = 0;
    localparam int unsigned CMD_ADDR_LSB  = DATA_W;
    localparam int unsigned CMD_WRITE_BIT = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

endpackage

// File: rtl/spi_apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module spi_apb_cmd_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_apb_master.sv
// APB3 requester for the SPI register block: queues local register commands and
// runs each one as a SETUP/ACCESS transfer with wait-state and timeout handling.
module spi_apb_master
    import spi_apb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e        state_q, state_d;
    logic [CMD_W-1:0]  fifo_wdata, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              timeout_hit;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // cmd_ready depends only on the registered full flag, never on a same-cycle pop
    assign cmd_ready = ~fifo_full;
    assign fifo_push = cmd_valid & ~fifo_full;

    always_comb begin
        fifo_wdata                            = '0;
        fifo_wdata[CMD_WRITE_BIT]             = cmd_write;
        fifo_wdata[CMD_ADDR_LSB +: ADDR_W]    = cmd_addr;
        fifo_wdata[CMD_WDATA_LSB +: DATA_W]   = cmd_wdata;
    end

    spi_apb_cmd_fifo #(
        .WIDTH(CMD_W),
        .DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .clk  (PCLK),
        .rst_n(PRESETn),
        .push (fifo_push),
        .pop  (fifo_pop),
        .wdata(fifo_wdata),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d       = state_q;
        fifo_pop      = 1'b0;
        wait_cnt_d    = wait_cnt_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    paddr_d    = fifo_head[CMD_ADDR_LSB +: ADDR_W];
                    pwdata_d   = fifo_head[CMD_WDATA_LSB +: DATA_W];
                    pwrite_d   = fifo_head[CMD_WRITE_BIT];
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (timeout_hit) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_apb_master.sv
// Bench for spi_apb_master: a scripted APB responder (per-transfer wait/error plan)
// plus a register-map reference model that predicts every response.
`timescale 1ns/1ps
module tb_spi_apb_master;
    import spi_apb_pkg::*;

    logic       PCLK = 1'b0, PRESETn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic [7:0] rsp_rdata, PWDATA, PRDATA;
    logic [2:0] PADDR;
    logic       PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int n_checks = 0, n_fail = 0;

    always #5 PCLK = ~PCLK;

    spi_apb_master #(.CMD_DEPTH(2), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Responder: wait states and error flag per transfer come from a plan indexed by transfer number
    int         plan_wait [256];
    bit         plan_err  [256];
    int         plan_idx = 0, cur_wait = 0, acc_n = 0;
    bit         cur_err = 1'b0;
    logic [7:0] slave_mem [8] = '{default: 8'h00};
    logic [7:0] model_mem [8] = '{default: 8'h00};

    // Transfer log and protocol watch
    logic [2:0] log_addr [256];
    int         log_acc  [256];
    bit         log_abort[256];
    int         xn = 0, viol = 0;
    logic       prev_sel = 1'b0, prev_done = 1'b0, prev_wr = 1'b0;
    logic [2:0] prev_addr = '0;
    logic [7:0] prev_wd = '0;

    assign PREADY  = PSEL && PENABLE && (acc_n >= cur_wait);
    assign PSLVERR = PREADY && cur_err;
    assign PRDATA  = slave_mem[PADDR];

    always @(posedge PCLK) begin
        if ((PENABLE && !PSEL) || (prev_done && PSEL) || (!prev_sel && PSEL && PENABLE) ||
            (prev_sel && PSEL && ({PADDR, PWRITE, PWDATA} != {prev_addr, prev_wr, prev_wd})))
            viol <= viol + 1;
        prev_done <= PSEL && PENABLE && PREADY;
        prev_sel  <= PSEL;
        prev_addr <= PADDR;
        prev_wr   <= PWRITE;
        prev_wd   <= PWDATA;
        if (PSEL && !PENABLE) begin
            cur_wait <= plan_wait[plan_idx % 256];
            cur_err  <= plan_err[plan_idx % 256];
            plan_idx <= plan_idx + 1;
        end
        if (PSEL && PENABLE) begin
            if (PREADY) begin
                log_addr[xn % 256]  <= PADDR;
                log_acc[xn % 256]   <= acc_n + 1;
                log_abort[xn % 256] <= 1'b0;
                xn    <= xn + 1;
                acc_n <= 0;
                if (PWRITE && !cur_err)
                    slave_mem[(PADDR == ADDR_DR_WR) ? ADDR_DR_RD : PADDR] <= PWDATA;
            end else begin
                acc_n <= acc_n + 1;
            end
        end else if (acc_n != 0) begin
            log_addr[xn % 256]  <= prev_addr;
            log_acc[xn % 256]   <= acc_n;
            log_abort[xn % 256] <= 1'b1;
            xn    <= xn + 1;
            acc_n <= 0;
        end
    end

    // Register-map model: returns the expected read data for a completed transfer
    function automatic logic [7:0] model_xfer(input bit w, input logic [2:0] a,
                                              input logic [7:0] d, input bit err);
        if (w) begin
            if (!err) model_mem[(a == ADDR_DR_WR) ? ADDR_DR_RD : a] = d;
            return 8'h00;
        end
        return model_mem[a];
    endfunction

    task automatic push_cmd(input logic w, input logic [2:0] a, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge PCLK); n++; end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL push_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] rd, output logic er, output logic to);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 500) begin @(negedge PCLK); n++; end
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
        rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
        if (rsp_valid === 1'b1) begin
            rsp_ready = 1'b1; @(negedge PCLK); rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [25:0] exp_v = {1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, cmd_ready} !== exp_v) begin
            n_fail++; $display("FAIL reset_held: got %h required %h",
                {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, cmd_ready}, exp_v);
        end
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, cmd_ready} !== exp_v) begin
            n_fail++; $display("FAIL reset_released: got %h required %h",
                {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, cmd_ready}, exp_v);
        end
    endtask

    task automatic test_zero_wait_write();
        logic [7:0] rd; logic er, to;
        plan_wait[plan_idx % 256] = 0; plan_err[plan_idx % 256] = 1'b0;
        void'(model_xfer(1'b1, ADDR_CR1, 8'hD5, 1'b0));
        push_cmd(1'b1, ADDR_CR1, 8'hD5);
        n_checks++;
        if (PSEL !== 1'b0) begin n_fail++; $display("FAIL zw_psel_e0: PSEL=%b required 0", PSEL); end
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 3'd0, 8'hD5}) begin
            n_fail++; $display("FAIL zw_setup: got %b_%b_%b_%h_%h required 1_0_1_0_d5", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
            n_fail++; $display("FAIL zw_access: PSEL/PENABLE/rsp_valid=%b required 110", {PSEL, PENABLE, rsp_valid});
        end
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {3'b001, 8'h00, 2'b00}) begin
            n_fail++; $display("FAIL zw_resp: got %b_%h_%b_%b required 001_00_0_0",
                {PSEL, PENABLE, rsp_valid}, rsp_rdata, rsp_err, rsp_timeout);
        end
        get_rsp(rd, er, to);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL zw_idle: rsp_valid/busy=%b required 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_spi_slave_rw();
        logic [7:0] rd; logic er, to; int n = 0; int base = xn;
        plan_wait[plan_idx % 256] = 1;       plan_err[plan_idx % 256] = 1'b0;
        plan_wait[(plan_idx + 1) % 256] = 1; plan_err[(plan_idx + 1) % 256] = 1'b0;
        void'(model_xfer(1'b1, ADDR_DR_WR, 8'hBE, 1'b0));
        push_cmd(1'b1, ADDR_DR_WR, 8'hBE);
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
        n_checks++;
        if (n != 4) begin n_fail++; $display("FAIL spi_latency: rsp_valid after %0d edges, required 4", n); end
        get_rsp(rd, er, to);
        n_checks++;
        if ({rd, er, to} !== {8'h00, 2'b00}) begin
            n_fail++; $display("FAIL spi_write_rsp: got %h/%b/%b required 00/0/0", rd, er, to);
        end
        push_cmd(1'b0, ADDR_DR_RD, 8'h00);
        get_rsp(rd, er, to);
        n_checks++;
        if ({rd, er, to} !== {model_xfer(1'b0, ADDR_DR_RD, 8'h00, 1'b0), 2'b00} || rd !== 8'hBE) begin
            n_fail++; $display("FAIL spi_read_rsp: got %h/%b/%b required be/0/0", rd, er, to);
        end
        n_checks++;
        if (log_acc[base % 256] != 2 || log_acc[(base + 1) % 256] != 2) begin
            n_fail++; $display("FAIL spi_wait_states: access cycles %0d,%0d required 2,2",
                log_acc[base % 256], log_acc[(base + 1) % 256]);
        end
    endtask

    task automatic test_slverr();
        logic [7:0] rd; logic er, to; int base = xn;
        plan_wait[plan_idx % 256] = 0;       plan_err[plan_idx % 256] = 1'b1;
        plan_wait[(plan_idx + 1) % 256] = 0; plan_err[(plan_idx + 1) % 256] = 1'b0;
        void'(model_xfer(1'b1, ADDR_CR2, 8'h11, 1'b1));
        void'(model_xfer(1'b1, ADDR_BR, 8'h22, 1'b0));
        push_cmd(1'b1, ADDR_CR2, 8'h11);
        push_cmd(1'b1, ADDR_BR, 8'h22);
        get_rsp(rd, er, to);
        n_checks++;
        if ({rd, er, to} !== {8'h00, 2'b10}) begin
            n_fail++; $display("FAIL slverr_rsp: got %h/%b/%b required 00/1/0", rd, er, to);
        end
        get_rsp(rd, er, to);
        n_checks++;
        if ({rd, er, to} !== {8'h00, 2'b00} || log_addr[(base + 1) % 256] !== ADDR_BR) begin
            n_fail++; $display("FAIL slverr_next: got %h/%b/%b addr %0d required 00/0/0 addr 2",
                rd, er, to, log_addr[(base + 1) % 256]);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rd; logic er, to; int base = xn;
        plan_wait[plan_idx % 256] = 100; plan_err[plan_idx % 256] = 1'b0;
        push_cmd(1'b0, ADDR_SR, 8'h00);
        get_rsp(rd, er, to);
        n_checks++;
        if ({rd, er, to} !== {8'h00, 2'b11}) begin
            n_fail++; $display("FAIL timeout_rsp: got %h/%b/%b required 00/1/1", rd, er, to);
        end
        n_checks++;
        if (log_abort[base % 256] !== 1'b1 || log_acc[base % 256] != 16) begin
            n_fail++; $display("FAIL timeout_len: aborted=%b access cycles %0d required 1 and 16",
                log_abort[base % 256], log_acc[base % 256]);
        end
    endtask

    task automatic test_back_to_back();
        bit w[3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] a[3] = '{ADDR_CR1, ADDR_CR1, ADDR_BR};
        logic [7:0] d[3] = '{8'h3C, 8'h00, 8'h81};
        logic [7:0] er_rd[3];
        logic [7:0] rd; logic er, to; int n = 0, bad = 0; int base = xn;
        for (int i = 0; i < 3; i++) begin
            plan_wait[(plan_idx + i) % 256] = i; plan_err[(plan_idx + i) % 256] = 1'b0;
            er_rd[i] = model_xfer(w[i], a[i], d[i], 1'b0);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(w[i], a[i], d[i]);
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_full: cmd_ready/busy=%b required 01", {cmd_ready, busy});
        end
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge PCLK); n++; end
        for (int i = 0; i < 6; i++) begin
            if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL} !== {1'b1, er_rd[0], 3'b000}) bad++;
            @(negedge PCLK);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL b2b_hold: %0d unstable cycles, rsp=%b/%h/%b PSEL=%b required 0",
                bad, rsp_valid, rsp_rdata, rsp_err, PSEL);
        end
        for (int i = 0; i < 3; i++) begin
            get_rsp(rd, er, to);
            n_checks++;
            if ({rd, er, to} !== {er_rd[i], 2'b00} || log_addr[(base + i) % 256] !== a[i]) begin
                n_fail++; $display("FAIL b2b_rsp%0d: got %h/%b/%b addr %0d required %h/0/0 addr %0d",
                    i, rd, er, to, log_addr[(base + i) % 256], er_rd[i], a[i]);
            end
        end
    endtask

    task automatic test_random();
        bit w[40]; logic [2:0] a[40]; logic [7:0] d[40]; logic [7:0] er_rd[40]; bit er_err[40];
        int p0 = plan_idx, base = xn, bad = 0;
        for (int i = 0; i < 40; i++) begin
            w[i] = 1'($urandom_range(0, 1));
            a[i] = 3'($urandom_range(0, 7));
            d[i] = 8'($urandom);
            plan_wait[(p0 + i) % 256] = int'($urandom_range(0, 3));
            plan_err[(p0 + i) % 256]  = ($urandom_range(0, 5) == 0);
            er_err[i] = plan_err[(p0 + i) % 256];
            er_rd[i]  = model_xfer(w[i], a[i], d[i], er_err[i]);
        end
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge PCLK);
                push_cmd(w[i], a[i], d[i]);
            end
            for (int i = 0; i < 40; i++) begin
                logic [7:0] rd; logic er, to;
                repeat ($urandom_range(0, 3)) @(negedge PCLK);
                get_rsp(rd, er, to);
                n_checks++;
                if ({rd, er, to} !== {er_rd[i], er_err[i], 1'b0}) begin
                    n_fail++; $display("FAIL rand_rsp%0d: got %h/%b/%b required %h/%b/0",
                        i, rd, er, to, er_rd[i], er_err[i]);
                end
            end
        join
        for (int i = 0; i < 40; i++)
            if (log_acc[(base + i) % 256] != plan_wait[(p0 + i) % 256] + 1) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rand_wait_states: %0d transfers wrong length, required 0", bad); end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL apb_protocol: %0d violations, required 0", viol); end
    endtask

    task automatic test_reset_mid_access();
        int n = 0, highs = 0;
        plan_wait[plan_idx % 256] = 100; plan_err[plan_idx % 256] = 1'b0;
        push_cmd(1'b0, ADDR_CR1, 8'h00);
        push_cmd(1'b0, ADDR_BR, 8'h00);
        while (PENABLE !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
        n_checks++;
        if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL rst_reach_access: PENABLE=%b required 1", PENABLE); end
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL rst_async: PSEL/PENABLE/rsp_valid/busy/cmd_ready=%b required 00001",
                {PSEL, PENABLE, rsp_valid, busy, cmd_ready});
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            if (PSEL !== 1'b0) highs++;
        end
        n_checks++;
        if (highs != 0 || {busy, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rst_discard: PSEL high %0d cycles busy/cmd_ready=%b required 0 and 01",
                highs, {busy, cmd_ready});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge PCLK);
        test_reset();
        test_zero_wait_write();
        test_spi_slave_rw();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_protocol();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_apb_master.md
Name: spi_apb_master

Overview:
APB requester for the SPI register block: the initiator side of the APB interface that the SPI slave interface serves. It accepts register read/write commands from a local controller over a valid/ready port and buffers them in a small FIFO. It executes each as an APB3 SETUP/ACCESS transfer with wait-state and timeout handling, then returns read data and error status on a response port.

Parameters:
CMD_DEPTH, 2, command FIFO entries (power of 2, ≥2)
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  3  register address
cmd_wdata  in  8  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  8  read data (0 for writes)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
busy  out  1  FSM not IDLE or FIFO not empty
PADDR  out  3  APB address
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWDATA  out  8  APB write data
PRDATA  in  8  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0. The FIFO is empty, so cmd_ready=1.
- Reset asserted mid-transfer: all outputs take reset values immediately and queued commands are discarded.
- Command push: occurs on cmd_valid&cmd_ready. A push and a pop in the same cycle are legal when the FIFO is full, but cmd_ready is still driven low while full (no combinational path from pop to cmd_ready).
- All APB outputs are registered.
- FSM states IDLE, SETUP, ACCESS, RESP.
- IDLE: if the FIFO is not empty, pop the head, load PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0, and go to SETUP. PADDR/PWDATA hold their last values while idle.
- SETUP: set PENABLE=1 and go to ACCESS unconditionally.
- ACCESS: PADDR/PWRITE/PWDATA/PSEL are held stable.
  - If PREADY=1: capture rsp_rdata=PRDATA for reads and 0 for writes; set rsp_err=PSLVERR, rsp_timeout=0; drop PSEL/PENABLE; set rsp_valid=1; go to RESP.
  - If PREADY=0: increment the wait counter. If TIMEOUT≠0 and the count reaches TIMEOUT, drop PSEL/PENABLE, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, and go to RESP.
  - The wait counter clears on entry to SETUP; its width is clog2(TIMEOUT+1).
- RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_ready, clear rsp_valid and go to IDLE.
- PSEL is low for at least one cycle between transfers, so the slave always sees IDLE between accesses.
- Latency, with a command accepted at edge E0:
  - PSEL rises after E1 and PENABLE after E2.
  - Zero wait states: PREADY sampled at E3, rsp_valid after E3.
  - Against the team's SPI slave (PREADY high one cycle after its ENABLE state): one wait state, rsp_valid after E4.
- PSLVERR is sampled only when PREADY=1 in ACCESS; it is ignored otherwise.
- At most one transfer is outstanding; there is no pipelining across responses.

Decomposition:
- Package spi_apb_pkg holds:
  - register addresses CR1=0, CR2=1, BR=2, DR_RD=3, DR_WR=5, SR (any other read address, e.g. 4);
  - FSM state encoding;
  - command record width (1+3+8=12 bits) and field offsets.
- Sub-module spi_apb_cmd_fifo: synchronous FIFO, width 12, depth CMD_DEPTH, with push/pop/full/empty, async active-low reset to empty.

Test Plan:
- Write CR1=0xD5 against a zero-wait responder → PSEL high 2 cycles, PENABLE 1 cycle, PADDR=0, PWDATA=0xD5; rsp_valid 1 cycle after PREADY with rsp_rdata=0x00, rsp_err=0.
- Write DR_WR=0xBE, then read DR_RD against the SPI slave model → each transfer has one wait state; the read returns rsp_rdata=0xBE, rsp_err=0.
- Write with responder driving PSLVERR=1 (tip=1) on its PREADY cycle → rsp_err=1, rsp_timeout=0; the next queued command still executes.
- Responder never asserts PREADY, TIMEOUT=16 → PSEL/PENABLE drop after 16 ACCESS wait cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Push 3 commands back-to-back with CMD_DEPTH=2 and rsp_ready=0 → cmd_ready deasserts while full; responses are held stable until rsp_ready; all 3 complete in order with PSEL low ≥1 cycle between them.
- Assert PRESETn=0 during ACCESS with 1 command queued → PSEL/PENABLE/rsp_valid=0 at once; after release, no APB activity occurs, busy=0, cmd_ready=1.
